pkt_read_arbiter: RTL and testbench



---
 rtl/pkt_read_arbiter_pkg.sv | 22 ++
 rtl/pkt_read_arbiter_if.sv | 32 +++
 rtl/pkt_read_arbiter_rr_arbiter_core.sv | 41 ++++
 rtl/pkt_read_arbiter.sv | 110 +++++++++++
 tb/tb_pkt_read_arbiter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/pkt_read_arbiter_pkg.sv
// Shared constants, tag type and helper for the packet-buffer read arbiter.
package pkt_read_arbiter_pkg;

    localparam int unsigned PORT_NUM_MAX   = 8;
    localparam int unsigned PKT_ADDR_W     = 16;
    localparam int unsigned PKT_DATA_W     = 134;
    localparam int unsigned MEM_RD_LATENCY = 2;
    localparam int unsigned PORT_IDX_W     = 3;

    typedef logic [PORT_IDX_W-1:0] port_idx_t;

    // One entry of the read-return pipeline: which port owns the word in flight.
    typedef struct packed {
        logic      valid;
        port_idx_t port;
    } rd_tag_t;

    function automatic logic [PORT_NUM_MAX-1:0] port_onehot(input port_idx_t p);
        return PORT_NUM_MAX'(1) << p;
    endfunction

endpackage

// File: rtl/pkt_read_arbiter_if.sv
// Requester and memory read-port signals of pkt_read_arbiter; slave = arbiter side.
interface pkt_read_arbiter_if
    import pkt_read_arbiter_pkg::*;
#(
    parameter int unsigned PORT_NUM = PORT_NUM_MAX,
    parameter int unsigned DATA_W   = PKT_DATA_W
);

    logic [PKT_ADDR_W*PORT_NUM-1:0] iv_pkt_raddr;
    logic [PORT_NUM-1:0]            iv_pkt_rd;
    logic [PORT_NUM-1:0]            ov_pkt_raddr_ack;
    logic [PKT_ADDR_W-1:0]          ov_mem_raddr;
    logic                           o_mem_rd;
    logic                           i_mem_rd_ready;
    logic [DATA_W-1:0]              iv_mem_rdata;
    logic [DATA_W-1:0]              ov_pkt_data;
    logic [PORT_NUM-1:0]            ov_pkt_data_wr;
    logic [PORT_IDX_W-1:0]          ov_last_grant;

    modport slave (
        input  iv_pkt_raddr, iv_pkt_rd, i_mem_rd_ready, iv_mem_rdata,
        output ov_pkt_raddr_ack, ov_mem_raddr, o_mem_rd, ov_pkt_data,
               ov_pkt_data_wr, ov_last_grant
    );

    modport master (
        output iv_pkt_raddr, iv_pkt_rd, i_mem_rd_ready, iv_mem_rdata,
        input  ov_pkt_raddr_ack, ov_mem_raddr, o_mem_rd, ov_pkt_data,
               ov_pkt_data_wr, ov_last_grant
    );

endinterface

// File: rtl/pkt_read_arbiter_rr_arbiter_core.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter_core
    import pkt_read_arbiter_pkg::*;
#(
    parameter int unsigned PORT_NUM = PORT_NUM_MAX
)(
    input  logic [PORT_NUM-1:0] req,
    input  port_idx_t           ptr,
    output logic [PORT_NUM-1:0] grant,
    output port_idx_t           grant_idx,
    output logic                grant_valid
);

    localparam int unsigned POS_W = PORT_IDX_W + 1;

    logic [PORT_NUM_MAX-1:0] req_ext;
    logic [PORT_NUM_MAX-1:0] grant_ext;

    assign req_ext = PORT_NUM_MAX'(req);

    always_comb begin
        logic [POS_W-1:0] pos;
        pos         = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int unsigned k = 0; k < PORT_NUM; k++) begin
            pos = {1'b0, ptr} + POS_W'(k);
            if (pos >= POS_W'(PORT_NUM)) begin
                pos = pos - POS_W'(PORT_NUM);
            end
            if (!grant_valid && req_ext[pos[PORT_IDX_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = pos[PORT_IDX_W-1:0];
            end
        end
    end

    assign grant_ext = grant_valid ? port_onehot(grant_idx) : '0;
    assign grant     = grant_ext[PORT_NUM-1:0];

endmodule

// File: rtl/pkt_read_arbiter.sv
// Round-robin sharing of the buffer-memory read port among per-port readers,
// with a tag pipeline that steers returned words back to the owning port.
module pkt_read_arbiter
    import pkt_read_arbiter_pkg::*;
#(
    parameter int unsigned PORT_NUM   = PORT_NUM_MAX,
    parameter int unsigned DATA_W     = PKT_DATA_W,
    parameter int unsigned RD_LATENCY = MEM_RD_LATENCY
)(
    input  logic               i_clk,
    input  logic               i_rst_n,
    pkt_read_arbiter_if.slave  bus
);

    logic [PORT_NUM-1:0]   eligible;
    logic [PORT_NUM-1:0]   grant;
    port_idx_t             grant_idx;
    logic                  grant_valid;
    logic                  issue;
    logic [PKT_ADDR_W-1:0] sel_raddr;

    port_idx_t             ptr_q;
    port_idx_t             last_grant_q;
    logic [PORT_NUM-1:0]   ack_q;
    logic                  mem_rd_q;
    logic [PKT_ADDR_W-1:0] mem_raddr_q;

    rd_tag_t               tag_q [RD_LATENCY];
    rd_tag_t               tag_exit;
    logic [PORT_NUM_MAX-1:0] exit_onehot;
    logic [PORT_NUM-1:0]   data_wr_q;
    logic [DATA_W-1:0]     data_q;

    // The ack register doubles as the mask: a port still holding rd in its ack cycle is skipped.
    assign eligible = bus.iv_pkt_rd & ~ack_q;

    rr_arbiter_core #(.PORT_NUM(PORT_NUM)) u_rr_arbiter_core (
        .req         (eligible),
        .ptr         (ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign issue = bus.i_mem_rd_ready & grant_valid;

    always_comb begin
        sel_raddr = '0;
        for (int unsigned i = 0; i < PORT_NUM; i++) begin
            if (grant_idx == PORT_IDX_W'(i)) begin
                sel_raddr = bus.iv_pkt_raddr[i*PKT_ADDR_W +: PKT_ADDR_W];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem_rd_q     <= 1'b0;
            ack_q        <= '0;
            mem_raddr_q  <= '0;
            last_grant_q <= '0;
            ptr_q        <= '0;
        end else begin
            mem_rd_q <= issue;
            ack_q    <= issue ? grant : '0;
            if (issue) begin
                mem_raddr_q  <= sel_raddr;
                last_grant_q <= grant_idx;
                ptr_q        <= (grant_idx == PORT_IDX_W'(PORT_NUM - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // Tag enters alongside o_mem_rd and exits in the cycle the memory word is valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned k = 0; k < RD_LATENCY; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0] <= '{valid: mem_rd_q, port: last_grant_q};
            for (int unsigned k = 1; k < RD_LATENCY; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign tag_exit    = tag_q[RD_LATENCY-1];
    assign exit_onehot = port_onehot(tag_exit.port);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_wr_q <= '0;
            data_q    <= '0;
        end else begin
            data_wr_q <= tag_exit.valid ? exit_onehot[PORT_NUM-1:0] : '0;
            if (tag_exit.valid) begin
                data_q <= bus.iv_mem_rdata;
            end
        end
    end

    assign bus.o_mem_rd         = mem_rd_q;
    assign bus.ov_mem_raddr     = mem_raddr_q;
    assign bus.ov_pkt_raddr_ack = ack_q;
    assign bus.ov_last_grant    = last_grant_q;
    assign bus.ov_pkt_data      = data_q;
    assign bus.ov_pkt_data_wr   = data_wr_q;

endmodule

// File: tb/tb_pkt_read_arbiter.sv
// Directed and random requests against a cycle-level round-robin/latency reference model.
module tb_pkt_read_arbiter;
    import pkt_read_arbiter_pkg::*;

    localparam int unsigned N   = 8;
    localparam int unsigned DW  = 134;
    localparam int unsigned RDL = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #4 clk = ~clk;

    pkt_read_arbiter_if #(.PORT_NUM(N), .DATA_W(DW)) bus ();

    pkt_read_arbiter #(.PORT_NUM(N), .DATA_W(DW), .RD_LATENCY(RDL)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    function automatic logic [DW-1:0] mem_word(input logic [15:0] x);
        return {6'h15, x, ~x, x ^ 16'h5A5A, x + 16'h1234, {x[7:0], x[15:8]},
                x ^ 16'hC3C3, x - 16'h0101, ~{x[3:0], x[15:4]}};
    endfunction

    // Memory: word for the address presented RDL cycles earlier
    logic [15:0] mpipe [RDL];
    always @(posedge clk) begin
        mpipe[0] <= bus.ov_mem_raddr;
        for (int k = 1; k < RDL; k++) mpipe[k] <= mpipe[k-1];
    end
    assign bus.iv_mem_rdata = mem_word(mpipe[RDL-1]);

    logic [15:0]   a [N];
    logic [N-1:0]  rd_v;
    logic          ready_v;
    logic [N-1:0]  pend;

    int            m_ptr;
    int            cyc;
    logic          m_rd;
    logic [N-1:0]  m_ack;
    logic [15:0]   m_raddr;
    logic [2:0]    m_last;
    logic [N-1:0]  m_wr;
    logic [DW-1:0] m_data;
    logic [N-1:0]  sched_wr   [16];
    logic [DW-1:0] sched_data [16];

    function automatic logic bit_at(input logic [N-1:0] v, input int i);
        logic [N-1:0] s;
        s = v >> i;
        return s[0];
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("o_mem_rd",   bus.o_mem_rd,         m_rd);
        chk("mem_raddr",  bus.ov_mem_raddr,     m_raddr);
        chk("ack",        bus.ov_pkt_raddr_ack, m_ack);
        chk("last_grant", bus.ov_last_grant,    m_last);
        chk("data_wr",    bus.ov_pkt_data_wr,   m_wr);
        chk("data",       bus.ov_pkt_data,      m_data);
    endtask

    task automatic model_reset();
        m_ptr = 0; m_rd = 1'b0; m_ack = '0; m_raddr = '0; m_last = '0;
        m_wr = '0; m_data = '0;
        for (int i = 0; i < 16; i++) begin
            sched_wr[i] = '0;
            sched_data[i] = '0;
        end
    endtask

    task automatic apply(input logic [N-1:0] r, input logic rdy);
        logic [16*N-1:0] vec;
        vec = '0;
        for (int i = N - 1; i >= 0; i--) vec = {vec[16*N-17:0], a[3'(i)]};
        rd_v = r;
        ready_v = rdy;
        bus.iv_pkt_raddr   = vec;
        bus.iv_pkt_rd      = r;
        bus.i_mem_rd_ready = rdy;
    endtask

    // Predict the outputs of the next cycle from the inputs just applied
    task automatic model_step();
        logic [N-1:0] elig;
        int g;
        int slot;
        elig = rd_v & ~m_ack;
        g = -1;
        for (int k = 0; k < N; k++)
            if (g < 0 && bit_at(elig, (m_ptr + k) % N)) g = (m_ptr + k) % N;
        slot = (cyc + RDL + 2) % 16;
        if (ready_v && g >= 0) begin
            m_rd    = 1'b1;
            m_ack   = N'(1) << g;
            m_raddr = a[3'(g)];
            m_last  = 3'(g);
            m_ptr   = (g + 1) % N;
            sched_wr[slot]   = N'(1) << g;
            sched_data[slot] = mem_word(a[3'(g)]);
        end else begin
            m_rd  = 1'b0;
            m_ack = '0;
        end
        cyc++;
        m_wr = sched_wr[cyc % 16];
        if (m_wr != '0) m_data = sched_data[cyc % 16];
        sched_wr[cyc % 16] = '0;
    endtask

    task automatic cycle(input logic [N-1:0] r, input logic rdy);
        @(negedge clk);
        check_outputs();
        apply(r, rdy);
        model_step();
    endtask

    task automatic hit_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        apply('0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_step();
    endtask

    initial begin
        cyc = 0;
        pend = '0;
        for (int i = 0; i < N; i++) a[3'(i)] = 16'(16'h0100 + i * 16'h0011);
        apply('0, 1'b0);
        #2;
        hit_reset();

        // single port 3
        a[3] = 16'h0180;
        cycle(8'h08, 1'b1);
        repeat (6) cycle('0, 1'b1);

        // all ports held requesting
        repeat (10) cycle(8'hFF, 1'b1);
        repeat (2) cycle('0, 1'b1);

        // ports 2 and 5, wrap after granting 5
        cycle(8'h20, 1'b1);
        cycle(8'h24, 1'b1);
        cycle(8'h24, 1'b1);
        repeat (2) cycle('0, 1'b1);

        // memory busy for 5 cycles with port 1 waiting
        a[1] = 16'hBEEF;
        repeat (5) cycle(8'h02, 1'b0);
        cycle(8'h02, 1'b1);
        repeat (5) cycle('0, 1'b1);

        // back-to-back 0 then 4, distinct returned words
        a[0] = 16'h1111;
        a[4] = 16'h4444;
        cycle(8'h80, 1'b1);
        cycle(8'h11, 1'b1);
        cycle(8'h10, 1'b1);
        repeat (6) cycle('0, 1'b1);

        // reset with a read in flight
        cycle(8'h04, 1'b1);
        cycle('0, 1'b1);
        cycle('0, 1'b1);
        hit_reset();
        repeat (6) cycle('0, 1'b1);
        cycle(8'h81, 1'b1);
        repeat (6) cycle('0, 1'b1);

        // random requesters: hold rd through the ack cycle, sometimes drop early
        for (int n = 0; n < 400; n++) begin
            logic [N-1:0] r;
            r = pend;
            for (int i = 0; i < N; i++)
                if (pend[3'(i)] && !m_ack[3'(i)] && $urandom_range(15) == 0) r[3'(i)] = 1'b0;
            pend = pend & ~m_ack;
            for (int i = 0; i < N; i++)
                if (!r[3'(i)] && !pend[3'(i)] && $urandom_range(2) == 0) begin
                    pend[3'(i)] = 1'b1;
                    a[3'(i)] = 16'($urandom);
                end
            cycle(r, $urandom_range(3) != 0);
        end
        repeat (8) cycle('0, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
